cmd_frame_regbank: RTL
======================

CMD_FRAME_REGBANK -- requirements
Module: cmd_frame_regbank

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 cs_in  input  1  SPI chip-select from the command detector; its rising edge marks a new word (asynchronous to clk).
REQ-005 data_in  input  16  word from the command detector; stable between cs_in rising edges.
REQ-006 dnum_in  input  8  word number from the command detector: 1 = header, 2..49 = payload, 50 = checksum.
REQ-007 rd_addr  input  6  payload read index, 0..47.
REQ-008 rd_data  output  16  active-bank word at rd_addr, registered.
REQ-009 frame_valid  output  1  one-cycle pulse when a frame is committed.
REQ-010 frame_err  output  1  one-cycle pulse when a frame is abandoned.
REQ-011 frame_cnt  output  16  count of committed frames; wraps at 0xFFFF->0.
REQ-012 busy  output  1  high in COLLECT, CHECK and COMMIT.

Function
REQ-013 SHALL synchronize cs_in through 2 flip-flops, detect the rising edge, and sample data_in/dnum_in in the edge-detect cycle; cs_in high and low phases are each >= 3 clk periods.
REQ-014 SHALL implement states IDLE, COLLECT, CHECK, COMMIT.
REQ-015 IDLE: a sample with dnum_in==1 and data_in==0x434D clears the accumulator, sets expected=2 and enters COLLECT; all other samples are ignored.
REQ-016 COLLECT: a sample with dnum_in==expected and 2<=expected<=49 writes shadow[expected-2], adds the word mod 2^16 to the accumulator, and increments expected.
REQ-017 COLLECT: a sample with dnum_in==50 and expected==50 latches the word as the checksum and enters CHECK on the next cycle.
REQ-018 COLLECT: a header sample (dnum_in==1, 0x434D) pulses frame_err, clears the accumulator, sets expected=2 and stays in COLLECT.
REQ-019 COLLECT: any other sample with a dnum_in mismatch pulses frame_err and returns to IDLE; the shadow and active banks are untouched.
REQ-020 CHECK, one cycle: a match enters COMMIT; a mismatch pulses frame_err and returns to IDLE.
REQ-021 COMMIT, one cycle: copies all 48 shadow words to the active bank in parallel, pulses frame_valid, increments frame_cnt, and returns to IDLE.
REQ-022 rd_data SHALL equal active[rd_addr] one cycle after rd_addr is applied, and 0 when rd_addr>47.
REQ-023 A cs edge detected during CHECK or COMMIT is processed as IDLE input after the return to IDLE; it is never dropped.

Reset
REQ-024 On rst SHALL clear all outputs, frame_cnt, the accumulator, the synchronizer, and the shadow and active banks to 0, and set state to IDLE; reset mid-frame discards the frame without a frame_err pulse.

Configuration
REQ-025 With CMD_CHECKSUM_EN defined, CHECK compares the accumulator with word 50.
REQ-026 Without CMD_CHECKSUM_EN, CHECK always passes to COMMIT, and word 50 is latched but ignored.

Structure
REQ-027 Package cmd_frame_pkg SHALL hold CM_HEADER=16'h434D, FRAME_LEN=50, PAYLOAD_WORDS=48 and the state enum.
REQ-028 The synchronizer and edge detector SHALL be the sub-module cs_edge_sync.

Verification
REQ-029 Header, payload 0x0100+k (k=0..47), checksum 0x3468 -> one frame_valid pulse, frame_cnt=1, rd_addr=5 gives 0x0105.
REQ-030 Same frame with checksum 0x3469 -> one frame_err pulse, active bank unchanged (frame_cnt stays 0); without CMD_CHECKSUM_EN -> frame_valid instead.
REQ-031 dnum_in sequence 1,2,3,5 -> frame_err at the 5 sample, state IDLE, busy=0.
REQ-032 A header restarts at dnum 20, followed by a full valid frame -> one frame_err pulse, then one frame_valid pulse, and the active bank holds the second frame.
REQ-033 rst asserted at dnum 30 -> no pulses, frame_cnt=0, and a following valid frame commits normally.
REQ-034 frame_cnt preloaded to 0xFFFF by 65535 frames, then one more valid frame -> frame_cnt=0x0000.

Source files
------------

// File: rtl/cmd_frame_pkg.sv
// Shared constants and FSM state type for the command-frame register bank.
package cmd_frame_pkg;

    localparam logic [15:0] CM_HEADER     = 16'h434D;
    localparam logic [7:0]  FRAME_LEN     = 8'd50;
    localparam int unsigned PAYLOAD_WORDS = 48;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_COMMIT
    } state_t;

    function automatic logic is_header(input logic [7:0] dnum, input logic [15:0] data);
        return (dnum == 8'd1) && (data == CM_HEADER);
    endfunction

endpackage

// File: rtl/cmd_frame_regbank_sync.sv
// cs_edge_sync: two-flop synchronizer for the asynchronous chip-select plus
// a single-cycle rising-edge pulse in the clk domain.
module cs_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_cs,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_cs};
            r_prev <= r_sync[1];
        end
    end

    assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/cmd_frame_regbank.sv
// Collects a 50-word command frame into a shadow bank and commits it to the
// readable active bank. Define CMD_CHECKSUM_EN to enforce the word-50 checksum.
module cmd_frame_regbank
    import cmd_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_in,
    input  logic [15:0] data_in,
    input  logic [7:0]  dnum_in,
    input  logic [5:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic        busy
);

`ifdef CMD_CHECKSUM_EN
    localparam logic CKSUM_EN = 1'b1;
`else
    localparam logic CKSUM_EN = 1'b0;
`endif

    logic        w_rise;
    state_t      r_state, w_state_nxt;

    logic        r_pend;
    logic [15:0] r_pend_data;
    logic [7:0]  r_pend_dnum;

    logic [15:0] r_acc;
    logic [15:0] r_cksum;
    logic [7:0]  r_expected;
    logic [15:0] r_shadow [PAYLOAD_WORDS];
    logic [15:0] r_active [PAYLOAD_WORDS];

    logic [15:0] r_rd_data;
    logic        r_frame_valid;
    logic        r_frame_err;
    logic [15:0] r_frame_cnt;

    logic        w_hold;
    logic        w_smp_vld;
    logic [15:0] w_smp_data;
    logic [7:0]  w_smp_dnum;
    logic        w_hdr;
    logic        w_ck_ok;
    logic [5:0]  w_wr_idx;

    logic        w_acc_clr;
    logic        w_wr_en;
    logic        w_cksum_ld;
    logic        w_commit;
    logic        w_err;

    cs_edge_sync u_cs_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .i_cs   (cs_in),
        .o_rise (w_rise)
    );

    // Edges arriving during CHECK/COMMIT are parked and replayed once back in IDLE.
    assign w_hold     = (r_state == ST_CHECK) || (r_state == ST_COMMIT);
    assign w_smp_vld  = ~w_hold & (r_pend | w_rise);
    assign w_smp_data = r_pend ? r_pend_data : data_in;
    assign w_smp_dnum = r_pend ? r_pend_dnum : dnum_in;
    assign w_hdr      = is_header(w_smp_dnum, w_smp_data);
    assign w_ck_ok    = ~CKSUM_EN | (r_acc == r_cksum);
    assign w_wr_idx   = 6'(r_expected - 8'd2);

    always_comb begin
        w_state_nxt = r_state;
        w_acc_clr   = 1'b0;
        w_wr_en     = 1'b0;
        w_cksum_ld  = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_smp_vld && w_hdr) begin
                    w_acc_clr   = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_smp_vld) begin
                    if (w_hdr) begin
                        w_err     = 1'b1;
                        w_acc_clr = 1'b1;
                    end else if ((w_smp_dnum == r_expected) && (r_expected >= 8'd2)
                                 && (r_expected < FRAME_LEN)) begin
                        w_wr_en = 1'b1;
                    end else if ((w_smp_dnum == FRAME_LEN) && (r_expected == FRAME_LEN)) begin
                        w_cksum_ld  = 1'b1;
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CHECK: begin
                if (w_ck_ok) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pend        <= 1'b0;
            r_pend_data   <= '0;
            r_pend_dnum   <= '0;
            r_acc         <= '0;
            r_cksum       <= '0;
            r_expected    <= '0;
            r_rd_data     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
            for (int unsigned i = 0; i < PAYLOAD_WORDS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_frame_valid <= w_commit;
            r_frame_err   <= w_err;

            if (w_rise && (w_hold || r_pend)) begin
                r_pend      <= 1'b1;
                r_pend_data <= data_in;
                r_pend_dnum <= dnum_in;
            end else if (r_pend && !w_hold) begin
                r_pend <= 1'b0;
            end

            if (w_acc_clr) begin
                r_acc      <= '0;
                r_expected <= 8'd2;
            end else if (w_wr_en) begin
                r_shadow[w_wr_idx] <= w_smp_data;
                r_acc              <= r_acc + w_smp_data;
                r_expected         <= r_expected + 8'd1;
            end

            if (w_cksum_ld) begin
                r_cksum <= w_smp_data;
            end

            if (w_commit) begin
                r_active    <= r_shadow;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            if (rd_addr < 6'(PAYLOAD_WORDS)) begin
                r_rd_data <= r_active[rd_addr];
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = (r_state != ST_IDLE);

endmodule
